// File: rtl/iic_init_sequencer.sv
// IIC init sequencer: walks a table of codec register writes/reads and feeds
// each entry to the IIC bus master driver as DA/RA/data, strobing vld low for
// one cycle, waiting for the driver to finish, checking ACK and read-back and
// retrying failed entries. Final status is held for the MicroBlaze registers.
// GAP_CYCLES and TIMEOUT must be at least 1.
module iic_init_sequencer #(
  parameter int N_ENTRIES  = 16,
  parameter int IDX_W      = 5,
  parameter int RETRIES    = 2,
  parameter int GAP_CYCLES = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  output logic [IDX_W-1:0] tbl_addr_o,
  input  logic [23:0]      tbl_entry_i,
  output logic [7:0]       DA_o,
  output logic [7:0]       RA_o,
  output logic [7:0]       data_o,
  output logic             vld_o,
  input  logic             rdy_i,
  input  logic [31:0]      ack_i,
  input  logic [31:0]      rd_data_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [IDX_W-1:0] err_idx_o,
  output logic [1:0]       err_code_o,
  output logic [31:0]      err_ack_o
);

  localparam int CNT_W = $clog2(TIMEOUT + GAP_CYCLES + 1);
  localparam int RET_W = $clog2(RETRIES + 2);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ENTRIES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [RET_W-1:0] RET_MAX  = RET_W'(RETRIES);

  localparam logic [1:0] CODE_NACK    = 2'b01;
  localparam logic [1:0] CODE_RDBACK  = 2'b10;
  localparam logic [1:0] CODE_TIMEOUT = 2'b11;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_FETCH     = 4'd1,
    ST_LOAD      = 4'd2,
    ST_ISSUE     = 4'd3,
    ST_WAIT_BUSY = 4'd4,
    ST_WAIT_DONE = 4'd5,
    ST_CHECK     = 4'd6,
    ST_FAIL      = 4'd7,
    ST_GAP       = 4'd8,
    ST_DONE      = 4'd9,
    ST_ERROR     = 4'd10
  } state_t;

  state_t           state_r, state_s;
  logic [IDX_W-1:0] idx_r, idx_s;
  logic [RET_W-1:0] retry_r, retry_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             start_q_r;
  logic             start_rise_s;
  logic [1:0]       fail_code_r, fail_code_s;
  logic [31:0]      fail_ack_r, fail_ack_s;

  logic [IDX_W-1:0] tbl_addr_r, tbl_addr_s;
  logic [7:0]       da_r, da_s, ra_r, ra_s, dat_r, dat_s;
  logic             vld_r, vld_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic             err_r, err_s;
  logic [IDX_W-1:0] err_idx_r, err_idx_s;
  logic [1:0]       err_code_r, err_code_s;
  logic [31:0]      err_ack_r, err_ack_s;

  // Only the low byte of the driver read data is meaningful.
  logic unused_rd_s;
  assign unused_rd_s = ^rd_data_i[31:8];

  assign start_rise_s = start_i & ~start_q_r;

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Counters, captured failure info and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_r       <= '0;
      retry_r     <= '0;
      cnt_r       <= '0;
      start_q_r   <= 1'b0;
      fail_code_r <= 2'b00;
      fail_ack_r  <= 32'h0;
      tbl_addr_r  <= '0;
      da_r        <= 8'h00;
      ra_r        <= 8'h00;
      dat_r       <= 8'h00;
      vld_r       <= 1'b1;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      err_idx_r   <= '0;
      err_code_r  <= 2'b00;
      err_ack_r   <= 32'h0;
    end else begin
      idx_r       <= idx_s;
      retry_r     <= retry_s;
      cnt_r       <= cnt_s;
      start_q_r   <= start_i;
      fail_code_r <= fail_code_s;
      fail_ack_r  <= fail_ack_s;
      tbl_addr_r  <= tbl_addr_s;
      da_r        <= da_s;
      ra_r        <= ra_s;
      dat_r       <= dat_s;
      vld_r       <= vld_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      err_r       <= err_s;
      err_idx_r   <= err_idx_s;
      err_code_r  <= err_code_s;
      err_ack_r   <= err_ack_s;
    end
  end

  // Next-state, counter and output decode; outputs are registered from the next state.
  always_comb begin
    state_s     = state_r;
    idx_s       = idx_r;
    retry_s     = retry_r;
    cnt_s       = cnt_r;
    fail_code_s = fail_code_r;
    fail_ack_s  = fail_ack_r;
    da_s        = da_r;
    ra_s        = ra_r;
    dat_s       = dat_r;
    done_s      = done_r;
    err_s       = err_r;
    err_idx_s   = err_idx_r;
    err_code_s  = err_code_r;
    err_ack_s   = err_ack_r;

    case (state_r)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start_rise_s) begin
          state_s    = ST_FETCH;
          idx_s      = '0;
          retry_s    = '0;
          done_s     = 1'b0;
          err_s      = 1'b0;
          err_idx_s  = '0;
          err_code_s = 2'b00;
          err_ack_s  = 32'h0;
        end else begin
          state_s = state_r;
        end
      end
      ST_FETCH: begin
        state_s = ST_LOAD;
      end
      ST_LOAD: begin
        da_s    = tbl_entry_i[23:16];
        ra_s    = tbl_entry_i[15:8];
        dat_s   = tbl_entry_i[7:0];
        state_s = ST_ISSUE;
      end
      ST_ISSUE: begin
        cnt_s   = '0;
        state_s = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        // A driver that is already busy on entry counts as busy seen.
        if (!rdy_i) begin
          state_s = ST_WAIT_DONE;
        end else if (cnt_r == TO_LAST) begin
          fail_code_s = CODE_TIMEOUT;
          fail_ack_s  = ack_i;
          state_s     = ST_FAIL;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (rdy_i) begin
          state_s = ST_CHECK;
        end else begin
          state_s = ST_WAIT_DONE;
        end
      end
      ST_CHECK: begin
        if (ack_i != 32'h0) begin
          fail_code_s = CODE_NACK;
          fail_ack_s  = ack_i;
          state_s     = ST_FAIL;
        end else if (da_r[0] && (rd_data_i[7:0] != dat_r)) begin
          fail_code_s = CODE_RDBACK;
          fail_ack_s  = ack_i;
          state_s     = ST_FAIL;
        end else begin
          retry_s = '0;
          if (idx_r == LAST_IDX) begin
            done_s  = 1'b1;
            state_s = ST_DONE;
          end else begin
            idx_s   = idx_r + IDX_W'(1);
            cnt_s   = '0;
            state_s = ST_GAP;
          end
        end
      end
      ST_FAIL: begin
        if (retry_r < RET_MAX) begin
          retry_s = retry_r + RET_W'(1);
          cnt_s   = '0;
          state_s = ST_GAP;
        end else begin
          err_idx_s  = idx_r;
          err_code_s = fail_code_r;
          err_ack_s  = fail_ack_r;
          err_s      = 1'b1;
          state_s    = ST_ERROR;
        end
      end
      ST_GAP: begin
        if (cnt_r == GAP_LAST) begin
          state_s = ST_FETCH;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    // vld idles high; it is low only for the single ISSUE cycle.
    vld_s = (state_s != ST_ISSUE);

    if ((state_s == ST_IDLE) || (state_s == ST_DONE) || (state_s == ST_ERROR)) begin
      busy_s = 1'b0;
    end else begin
      busy_s = 1'b1;
    end

    // The ROM address is presented for the whole FETCH cycle.
    if (state_s == ST_FETCH) begin
      tbl_addr_s = idx_s;
    end else begin
      tbl_addr_s = tbl_addr_r;
    end
  end

  assign tbl_addr_o = tbl_addr_r;
  assign DA_o       = da_r;
  assign RA_o       = ra_r;
  assign data_o     = dat_r;
  assign vld_o      = vld_r;
  assign busy_o     = busy_r;
  assign done_o     = done_r;
  assign err_o      = err_r;
  assign err_idx_o  = err_idx_r;
  assign err_code_o = err_code_r;
  assign err_ack_o  = err_ack_r;

endmodule

// File: tb/tb_iic_init_sequencer.sv
// Scoreboard bench for iic_init_sequencer: expected transactions and final
// run status are queued by the stimulus; a monitor pops and compares them on
// every vld_o falling edge and every busy_o falling edge.
module tb_iic_init_sequencer;

  localparam int IDX_W = 5;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             start_i;
  logic [IDX_W-1:0] tbl_addr_o;
  logic [23:0]      tbl_entry_i;
  logic [7:0]       DA_o, RA_o, data_o;
  logic             vld_o;
  logic             rdy_i;
  logic [31:0]      ack_i, rd_data_i;
  logic             busy_o, done_o, err_o;
  logic [IDX_W-1:0] err_idx_o;
  logic [1:0]       err_code_o;
  logic [31:0]      err_ack_o;

  iic_init_sequencer #(
    .N_ENTRIES(3), .IDX_W(IDX_W), .RETRIES(2), .GAP_CYCLES(4), .TIMEOUT(64)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .tbl_addr_o(tbl_addr_o), .tbl_entry_i(tbl_entry_i),
    .DA_o(DA_o), .RA_o(RA_o), .data_o(data_o), .vld_o(vld_o),
    .rdy_i(rdy_i), .ack_i(ack_i), .rd_data_i(rd_data_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .err_idx_o(err_idx_o), .err_code_o(err_code_o), .err_ack_o(err_ack_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [23:0] ent; int gap; } txn_t;

  localparam logic [23:0] T0 = 24'hEA_10_11;
  localparam logic [23:0] T1 = 24'hEA_12_13;
  localparam logic [23:0] T2 = 24'h76_20_21;
  localparam logic [23:0] RD = 24'hEB_49_C0;

  txn_t        txq[$];
  logic [41:0] stq[$];
  logic [31:0] ack_q[$];
  logic [23:0] tbl_mem [0:3];

  int          n_checks = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          n_falls = 0;
  logic        drv_stuck = 1'b0;
  logic [31:0] drv_rd = 32'h0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_txn(input logic [23:0] ent, input int gap);
    txn_t t;
    t.ent = ent;
    t.gap = gap;
    txq.push_back(t);
  endtask

  // status word: {done, err, vld, err_idx, err_code, err_ack}
  task automatic push_st(input logic d, input logic e, input logic [4:0] idx,
                         input logic [1:0] code, input logic [31:0] ack);
    stq.push_back({d, e, 1'b1, idx, code, ack});
  endtask

  // Synchronous table ROM: data appears one cycle after the address.
  initial begin : rom
    logic [IDX_W-1:0] a;
    tbl_entry_i = 24'h0;
    a = '0;
    forever begin
      @(negedge clk_i);
      a = tbl_addr_o;
      @(posedge clk_i);
      #1 tbl_entry_i = (a < 5'd4) ? tbl_mem[a[1:0]] : 24'h0;
    end
  end

  // IIC driver model: rdy falls 2 cycles after the vld fall, rises 30 cycles later.
  initial begin : driver
    int          cnt;
    logic [31:0] cur_ack;
    cnt = 0;
    cur_ack = 32'h0;
    rdy_i = 1'b1;
    ack_i = 32'h0;
    rd_data_i = 32'h0;
    forever begin
      @(posedge clk_i);
      #1;
      if (rst_i) begin
        cnt = 0;
        rdy_i = 1'b1;
      end else if (cnt == 0) begin
        if (!vld_o && !drv_stuck) begin
          cnt = 1;
          cur_ack = 32'h0;
          if (ack_q.size() > 0) cur_ack = ack_q.pop_front();
        end
      end else begin
        cnt++;
        if (cnt == 3) begin
          rdy_i = 1'b0;
          ack_i = cur_ack;
          rd_data_i = drv_rd;
        end else if (cnt == 33) begin
          rdy_i = 1'b1;
          cnt = 0;
        end
      end
    end
  end

  // Monitor: compares issued transactions, strobe width, spacing and end-of-run status.
  initial begin : monitor
    logic pv, pb;
    int   low_cnt, last_fall;
    txn_t t;
    logic [41:0] s;
    pv = 1'b1; pb = 1'b0; low_cnt = 0; last_fall = 0;
    forever begin
      @(negedge clk_i);
      cyc++;
      if (pv && !vld_o) begin
        n_falls++;
        if (txq.size() == 0) begin
          n_checks++; n_err++;
          $display("FAIL unexpected_issue actual=%0h required=none", {DA_o, RA_o, data_o});
        end else begin
          t = txq.pop_front();
          chk("txn_da_ra_data", {40'h0, DA_o, RA_o, data_o}, {40'h0, t.ent});
          if (t.gap > 0) chk("issue_spacing", 64'(cyc - last_fall), 64'(t.gap));
        end
        last_fall = cyc;
      end
      if (!vld_o) begin
        low_cnt++;
      end else if (!pv) begin
        chk("vld_width", 64'(low_cnt), 64'd1);
        low_cnt = 0;
      end
      if (pb && !busy_o) begin
        if (stq.size() == 0) begin
          n_checks++; n_err++;
          $display("FAIL unexpected_end actual=busy_fell required=none");
        end else begin
          s = stq.pop_front();
          chk("run_status", {22'h0, done_o, err_o, vld_o, err_idx_o, err_code_o, err_ack_o},
              {22'h0, s});
        end
      end
      pv = vld_o;
      pb = busy_o;
    end
  end

  task automatic start_run();
    @(posedge clk_i); #1 start_i = 1'b1;
    @(posedge clk_i); #1 start_i = 1'b0;
    chk("busy_after_start", 64'(busy_o), 64'd1);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (busy_o && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    if (busy_o) begin
      n_checks++; n_err++;
      $display("FAIL %s_run_bound actual=busy required=idle", name);
    end
    repeat (3) @(negedge clk_i);
    chk({name, "_txn_left"}, 64'(txq.size()), 64'd0);
    chk({name, "_status_left"}, 64'(stq.size()), 64'd0);
  endtask

  task automatic load_tbl(input logic [23:0] a, input logic [23:0] b, input logic [23:0] c);
    tbl_mem[0] = a; tbl_mem[1] = b; tbl_mem[2] = c; tbl_mem[3] = 24'h0;
  endtask

  initial begin : main
    int n;
    rst_i = 1'b1;
    start_i = 1'b0;
    load_tbl(T0, T1, T2);
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    chk("reset_vld", 64'(vld_o), 64'd1);
    chk("reset_flags", {61'h0, busy_o, done_o, err_o}, 64'h0);
    chk("reset_regs", {IDX_W'(0), tbl_addr_o, DA_o, RA_o, data_o, err_idx_o, err_code_o},
        64'h0);
    chk("reset_err_ack", {32'h0, err_ack_o}, 64'h0);

    // Write path: three clean writes.
    ack_q = '{32'h0, 32'h0, 32'h0};
    push_txn(T0, 0); push_txn(T1, 40); push_txn(T2, 40);
    push_st(1'b1, 1'b0, 5'd0, 2'b00, 32'h0);
    start_run();
    wait_idle("write", 2000);

    // Persistent NACK at entry 1: three attempts, entry 2 never issued.
    ack_q = '{32'h0, 32'h4, 32'h4, 32'h4};
    push_txn(T0, 0); push_txn(T1, 40); push_txn(T1, 41); push_txn(T1, 41);
    push_st(1'b0, 1'b1, 5'd1, 2'b01, 32'h4);
    start_run();
    wait_idle("nack", 2000);

    // Transient NACK on entry 0, plus a start pulse mid-run that must be ignored.
    ack_q = '{32'h5, 32'h0, 32'h0, 32'h0};
    push_txn(T0, 0); push_txn(T0, 41); push_txn(T1, 40); push_txn(T2, 40);
    push_st(1'b1, 1'b0, 5'd0, 2'b00, 32'h0);
    start_run();
    repeat (20) @(posedge clk_i);
    #1 start_i = 1'b1;
    @(posedge clk_i); #1 start_i = 1'b0;
    wait_idle("transient", 2000);

    // Read-back mismatch: C0 expected, 80 returned.
    load_tbl(RD, T1, T2);
    drv_rd = 32'h80;
    ack_q = '{32'h0, 32'h0, 32'h0};
    push_txn(RD, 0); push_txn(RD, 41); push_txn(RD, 41);
    push_st(1'b0, 1'b1, 5'd0, 2'b10, 32'h0);
    start_run();
    wait_idle("rdback", 2000);
    drv_rd = 32'h0;

    // Timeout: driver never drops rdy.
    load_tbl(T0, T1, T2);
    drv_stuck = 1'b1;
    ack_q.delete();
    push_txn(T0, 0); push_txn(T0, 72); push_txn(T0, 72);
    push_st(1'b0, 1'b1, 5'd0, 2'b11, 32'h0);
    start_run();
    wait_idle("timeout", 2000);
    chk("timeout_vld_idle", 64'(vld_o), 64'd1);
    drv_stuck = 1'b0;

    // Reset during WAIT_DONE of entry 1, then a fresh run from index 0.
    ack_q = '{32'h0, 32'h0};
    push_txn(T0, 0); push_txn(T1, 40);
    n = n_falls;
    start_run();
    begin
      int k;
      k = 0;
      while (n_falls < n + 2 && k < 500) begin
        @(negedge clk_i);
        k++;
      end
      if (n_falls < n + 2) begin
        n_checks++; n_err++;
        $display("FAIL midrst_bound actual=%0d required=%0d", n_falls - n, 2);
      end
    end
    repeat (10) @(posedge clk_i);
    push_st(1'b0, 1'b0, 5'd0, 2'b00, 32'h0);
    #1 rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    chk("midrst_vld", 64'(vld_o), 64'd1);
    chk("midrst_regs", {29'h0, busy_o, done_o, err_o, tbl_addr_o, DA_o, RA_o, data_o},
        64'h0);
    chk("midrst_status_left", 64'(stq.size()), 64'd0);
    ack_q = '{32'h0, 32'h0, 32'h0};
    push_txn(T0, 0); push_txn(T1, 40); push_txn(T2, 40);
    push_st(1'b1, 1'b0, 5'd0, 2'b00, 32'h0);
    start_run();
    wait_idle("rerun", 2000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
